pipe_hazard_fwd: RTL



---
 rtl/pipe_hazard_fwd_pkg.sv | 19 +
 rtl/pipe_hazard_fwd_if.sv | 42 ++++
 rtl/pipe_hazard_fwd_port_sel.sv | 52 +++++
 rtl/pipe_hazard_fwd.sv | 86 ++++++++
 4 files changed

// File: rtl/pipe_hazard_fwd_pkg.sv
// Shared types for the hazard/forwarding controller.
// Entry layout, zero register and select-width helper.
package pipe_pkg;

  localparam int AW_MAX = 8;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [AW_MAX-1:0] aw;
  } hz_entry_t;

  function automatic int fsel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_fwd_if.sv
// Decode-side bundle for the hazard controller.
// Master drives decode info, slave returns operands.
interface pipe_hazard_fwd_if #(
  parameter int DATA_W    = 64,
  parameter int REG_AW    = 5,
  parameter int NUM_RD    = 2,
  parameter int FWD_DEPTH = 3,
  parameter int CNT_W     = 32
);
  import pipe_pkg::*;

  localparam int SW = fsel_w(FWD_DEPTH);

  logic                          dec_valid;
  logic [REG_AW-1:0]             dec_aw;
  logic                          dec_regwrite;
  logic                          dec_memtoreg;
  logic [NUM_RD*REG_AW-1:0]      rd_addr;
  logic [NUM_RD-1:0]             rd_used;
  logic [NUM_RD*DATA_W-1:0]      rf_data;
  logic [FWD_DEPTH*DATA_W-1:0]   stage_data;
  logic                          flush;
  logic [NUM_RD*DATA_W-1:0]      opnd;
  logic [NUM_RD*SW-1:0]          fwd_sel;
  logic                          stall;
  logic [CNT_W-1:0]              stall_cnt;

  modport master (
    output dec_valid, dec_aw, dec_regwrite,
    output dec_memtoreg, rd_addr, rd_used,
    output rf_data, stage_data, flush,
    input  opnd, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_aw, dec_regwrite,
    input  dec_memtoreg, rd_addr, rd_used,
    input  rf_data, stage_data, flush,
    output opnd, fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_fwd_port_sel.sv
// Per-read-port priority match and operand mux.
// Youngest matching stage wins; flags a too-early load.
module fwd_port_sel #(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_AVAIL = 1,
  parameter int ZERO_REG   = 31,
  parameter int SW         = 2
) (
  input  pipe_pkg::hz_entry_t [FWD_DEPTH-1:0] ent,
  input  logic [REG_AW-1:0]            rd_addr,
  input  logic                         rd_used,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]  stage_data,
  output logic [DATA_W-1:0]            opnd,
  output logic [SW-1:0]                sel,
  output logic                         stall_req
);
  import pipe_pkg::*;

  logic [FWD_DEPTH-1:0] match;
  logic                 nz;
  logic                 is_ld;

  assign nz = (rd_addr != REG_AW'(ZERO_REG));

  // Which tracked stages produce this register.
  always_comb begin
    match = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      match[k] = ent[k].valid & ent[k].regwrite & nz &
                 (ent[k].aw == AW_MAX'(rd_addr));
    end
  end

  // Scan oldest to youngest so the lowest stage wins.
  always_comb begin
    opnd  = rf_data;
    sel   = '0;
    is_ld = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        opnd  = stage_data[k*DATA_W +: DATA_W];
        sel   = SW'(k + 1);
        is_ld = ent[k].memtoreg && (k < LOAD_AVAIL);
      end
    end
    stall_req = rd_used & is_ld;
  end

endmodule

// File: rtl/pipe_hazard_fwd.sv
// Hazard detection and operand forwarding beside decode.
// Tracks in-flight writers, stalls on load-use, counts stalls.
module pipe_hazard_fwd #(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 5,
  parameter int NUM_RD     = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_AVAIL = 1,
  parameter int ZERO_REG   = pipe_pkg::ZERO_REG,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               reset_n,
  pipe_hazard_fwd_if.slave  bus
);
  import pipe_pkg::*;

  localparam int SW = fsel_w(FWD_DEPTH);

  hz_entry_t [FWD_DEPTH-1:0]      ent_q, ent_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_RD-1:0]              stall_req;
  logic [NUM_RD-1:0][DATA_W-1:0]  opnd_w;
  logic [NUM_RD-1:0][SW-1:0]      sel_w;
  logic                           stall;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    fwd_port_sel #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_AVAIL (LOAD_AVAIL),
      .ZERO_REG   (ZERO_REG),
      .SW         (SW)
    ) u_sel (
      .ent        (ent_q),
      .rd_addr    (bus.rd_addr[gi*REG_AW +: REG_AW]),
      .rd_used    (bus.rd_used[gi]),
      .rf_data    (bus.rf_data[gi*DATA_W +: DATA_W]),
      .stage_data (bus.stage_data),
      .opnd       (opnd_w[gi]),
      .sel        (sel_w[gi]),
      .stall_req  (stall_req[gi])
    );
  end

  assign stall         = |stall_req;
  assign bus.stall     = stall;
  assign bus.opnd      = opnd_w;
  assign bus.fwd_sel   = sel_w;
  assign bus.stall_cnt = cnt_q;

  // Shift tracking; a held or flushed decode enters as a bubble.
  always_comb begin
    ent_d[0] = '0;
    if (bus.dec_valid && !stall && !bus.flush) begin
      ent_d[0].valid    = 1'b1;
      ent_d[0].regwrite = bus.dec_regwrite;
      ent_d[0].memtoreg = bus.dec_memtoreg;
      ent_d[0].aw       = AW_MAX'(bus.dec_aw);
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      ent_d[k] = ent_q[k-1];
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tracking and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
